pcm_rom_reader: RTL and testbench
=================================

PCM_ROM_READER -- requirements
Module: pcm_rom_reader

Interface
REQ-001 Parameter BASE_WORD, default 29'h0600000: DDRAM 64-bit word address of PCM ROM byte 0.
REQ-002 clk_sys  in  1  single clock for the whole block; all DDRAM and requester signals are synchronous to it.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 flush  in  1  level; high while the ROM is being (re)downloaded; invalidates cached data.
REQ-005 rd  in  1  single-cycle read strobe from the PCM engine.
REQ-006 addr  in  18  byte address, sampled on the cycle rd=1.
REQ-007 dout  out  8  byte returned for the accepted address; valid on the cycle rdy=1 and held afterwards.
REQ-008 rdy  out  1  single-cycle pulse, one per accepted request.
REQ-009 DDRAM_BUSY  in  1  DDRAM command back-pressure.
REQ-010 DDRAM_RD  out  1  read command.
REQ-011 DDRAM_ADDR  out  29  word address.
REQ-012 DDRAM_BURSTCNT  out  8  burst length.
REQ-013 DDRAM_DOUT  in  64  read data.
REQ-014 DDRAM_DOUT_READY  in  1  read-data valid.
REQ-015 DDRAM_WE, DDRAM_DIN, DDRAM_BE  out  1/64/8  constants 0, 64'h0 and 8'hFF.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-017 IDLE: a request is taken from rd, or from the pending slot if one is held.
 - Hit (line valid and tag == addr[17:3]) -> RESP; rdy rises exactly 1 cycle after the strobe.
 - Miss -> ISSUE.
REQ-018 ISSUE: DDRAM_RD=1, DDRAM_BURSTCNT=1, DDRAM_ADDR=BASE_WORD+addr[17:3] (29-bit add, wraps modulo 2^29). All three are held stable while DDRAM_BUSY=1; on DDRAM_RD=1 with DDRAM_BUSY=0 the command is accepted and the FSM goes to WAIT.
REQ-019 WAIT: DDRAM_RD=0. On DDRAM_DOUT_READY the line is loaded with DDRAM_DOUT and the tag is set; then -> RESP.
REQ-020 RESP: dout=line[8*addr[2:0] +: 8]; rdy=1 for one cycle; -> IDLE. Miss latency is exactly 1 cycle after the DOUT_READY cycle.
REQ-021 Pending slot, one deep: an rd strobe that arrives while the FSM is not in IDLE stores its address; a later strobe overwrites it (last wins). The slot is served at the next IDLE entry, with no idle cycle in between.
REQ-022 Every accepted request produces exactly one rdy. An issued DDRAM read is never abandoned.
REQ-023 flush=1 clears valid immediately. A fill completing while flush=1 still returns its byte to the requester but leaves valid=0.
REQ-024 rd=1 while flush=1 is served as a miss.
REQ-025 addr 18'h3FFFF maps to word BASE_WORD+15'h7FFF, byte 7; no carry into the next word.
REQ-026 rd=1 on the same cycle rdy=1 is a new request; it is treated as pending and served next.

Reset
REQ-027 reset_n=0, asynchronously:
 - state=IDLE; valid=0; pending cleared.
 - rdy=0, DDRAM_RD=0, dout=8'h00, DDRAM_ADDR=BASE_WORD, DDRAM_BURSTCNT=8'd1.
REQ-028 Reset during ISSUE or WAIT drops the transaction. A DDRAM_DOUT_READY that arrives after reset releases, while the FSM is in IDLE, is ignored.

Configuration
REQ-029 Macro PCM_ROM_LINE_CACHE_EN.
 - Defined: the one-line cache of REQ-017 is present.
 - Undefined: every request is treated as a miss and goes through ISSUE; no tag or valid storage exists; flush has no effect on data.

Structure
REQ-030 A shared package pcm_rom_pkg holds:
 - the FSM state enum;
 - the constants WORD_BITS=64, ADDR_BITS=18 and BURST_ONE=8'd1.
REQ-031 Sub-module pcm_rom_line (tag, valid, 64-bit data and byte select) is instantiated only when PCM_ROM_LINE_CACHE_EN is defined.

Verification
REQ-032 Cold read: rd with addr=18'h00005, DDRAM_BUSY=0, DOUT_READY 4 cycles later carrying 64'h8877665544332211 -> DDRAM_ADDR=BASE_WORD, dout=8'h66, one rdy pulse.
REQ-033 Hit, with the cache enabled: after REQ-032, rd with addr=18'h00002 -> rdy 1 cycle later with dout=8'h33 and no DDRAM_RD.
REQ-034 Back-pressure: DDRAM_BUSY=1 for 5 cycles during ISSUE -> DDRAM_RD and DDRAM_ADDR held stable across those cycles; exactly one command is accepted.
REQ-035 Pending: two rd strobes (addr 18'h00010, then 18'h00018) 2 cycles apart, both misses -> two DDRAM reads to words +2 and +3 in order, and two rdy pulses.
REQ-036 Flush: flush pulse during WAIT, then rd to the same word -> the first rdy is returned; the second request issues a new DDRAM_RD.
REQ-037 Wrap: addr=18'h3FFFF -> DDRAM_ADDR=BASE_WORD+29'h7FFF and dout=DDRAM_DOUT[63:56].

Source files
------------

// File: rtl/pcm_rom_pkg.sv
// pcm_rom_pkg
// Shared definitions for the PCM ROM reader: FSM state type, data/address
// widths, the fixed DDRAM burst length and a byte-lane picker used by both
// the reader and its optional line cache.
package pcm_rom_pkg;

    localparam int         WORD_BITS = 64;
    localparam int         ADDR_BITS = 18;
    localparam int         TAG_BITS  = ADDR_BITS - 3;
    localparam logic [7:0] BURST_ONE = 8'd1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } pcm_state_t;

    // Byte lane 0 is the least significant byte of the 64-bit DDRAM word.
    function automatic logic [7:0] pick_byte(input logic [WORD_BITS-1:0] word,
                                             input logic [2:0]           sel);
        return word[{sel, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/pcm_rom_line.sv
// pcm_rom_line
// One-line cache for the PCM ROM reader: holds one 64-bit DDRAM word, its tag
// and a valid bit, and returns the selected byte of the held word.
// Ports:
//   clk_sys, reset_n    clock, asynchronous active-low reset
//   flush               level; clears valid and suppresses hits while high
//   load                store load_tag/load_data (valid set unless flushing)
//   load_tag, load_data tag (addr[17:3]) and word of a completed fill
//   lookup_tag          tag of the request being looked up
//   byte_sel            byte lane of the request
//   hit                 held word matches lookup_tag and is usable
//   byte_out            selected byte of the held word
module pcm_rom_line
    import pcm_rom_pkg::*;
(
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 load,
    input  logic [TAG_BITS-1:0]  load_tag,
    input  logic [WORD_BITS-1:0] load_data,
    input  logic [TAG_BITS-1:0]  lookup_tag,
    input  logic [2:0]           byte_sel,
    output logic                 hit,
    output logic [7:0]           byte_out
);

    logic                 valid;
    logic [TAG_BITS-1:0]  tag;
    logic [WORD_BITS-1:0] data;

    // A fill that lands while flush is high still updates the storage so the
    // requester gets its byte, but must not be trusted afterwards.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else begin
            if (load) begin
                tag  <= load_tag;
                data <= load_data;
            end
            if (flush) begin
                valid <= 1'b0;
            end else if (load) begin
                valid <= 1'b1;
            end
        end
    end

    // flush gates the hit combinationally so a strobe during a download is
    // always served from DDRAM.
    assign hit      = valid && !flush && (tag == lookup_tag);
    assign byte_out = pick_byte(data, byte_sel);

endmodule

// File: rtl/pcm_rom_reader.sv
// pcm_rom_reader
// Byte reader for a PCM sample ROM stored in DDRAM. Each rd strobe returns
// one byte with a single-cycle rdy pulse; misses fetch one 64-bit word with a
// burst of one. One further strobe may arrive while a request is in flight;
// it is held in a one-deep pending slot (last strobe wins).
// Configuration macro: PCM_ROM_LINE_CACHE_EN adds a one-line word cache
// (pcm_rom_line); without it every request reads DDRAM.
// Ports:
//   clk_sys, reset_n        clock, asynchronous active-low reset
//   flush                   high while the ROM is (re)downloaded
//   rd, addr                read strobe and byte address
//   dout, rdy               returned byte (held) and completion pulse
//   DDRAM_*                 read-only DDRAM command/data interface
module pcm_rom_reader
    import pcm_rom_pkg::*;
#(
    parameter logic [28:0] BASE_WORD = 29'h0600000
)
(
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 rd,
    input  logic [ADDR_BITS-1:0] addr,
    output logic [7:0]           dout,
    output logic                 rdy,
    input  logic                 DDRAM_BUSY,
    output logic                 DDRAM_RD,
    output logic [28:0]          DDRAM_ADDR,
    output logic [7:0]           DDRAM_BURSTCNT,
    input  logic [WORD_BITS-1:0] DDRAM_DOUT,
    input  logic                 DDRAM_DOUT_READY,
    output logic                 DDRAM_WE,
    output logic [WORD_BITS-1:0] DDRAM_DIN,
    output logic [7:0]           DDRAM_BE
);

    pcm_state_t           state;
    pcm_state_t           next_state;
    logic                 pend_valid;
    logic [ADDR_BITS-1:0] pend_addr;
    logic [ADDR_BITS-1:0] req_addr;
    logic [ADDR_BITS-1:0] cur_addr;
    logic                 cur_valid;
    logic                 take_req;
    logic                 fill;
    logic                 hit;
    logic [7:0]           line_byte;

    // The pending slot has priority over a fresh strobe so older requests
    // are never starved.
    assign cur_valid = pend_valid || rd;
    assign cur_addr  = pend_valid ? pend_addr : addr;

`ifdef PCM_ROM_LINE_CACHE_EN
    pcm_rom_line u_line (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .flush      (flush),
        .load       (fill),
        .load_tag   (req_addr[ADDR_BITS-1:3]),
        .load_data  (DDRAM_DOUT),
        .lookup_tag (cur_addr[ADDR_BITS-1:3]),
        .byte_sel   (cur_addr[2:0]),
        .hit        (hit),
        .byte_out   (line_byte)
    );
`else
    logic [TAG_BITS:0] unused_nocache;
    assign unused_nocache = {flush, req_addr[ADDR_BITS-1:3]};
    assign hit            = 1'b0;
    assign line_byte      = 8'h00;
`endif

    always_comb begin
        next_state = state;
        take_req   = 1'b0;
        fill       = 1'b0;
        case (state)
            IDLE: begin
                if (cur_valid) begin
                    take_req   = 1'b1;
                    next_state = hit ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                if (!DDRAM_BUSY) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (DDRAM_DOUT_READY) begin
                    fill       = 1'b1;
                    next_state = RESP;
                end
            end
            RESP: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // dout is loaded on the edge that enters RESP, so it is valid together
    // with rdy and holds until the next completion. DDRAM_ADDR is a register
    // so it stays stable for the whole ISSUE phase under back-pressure.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            req_addr   <= '0;
            DDRAM_ADDR <= BASE_WORD;
            dout       <= 8'h00;
            rdy        <= 1'b0;
        end else begin
            state <= next_state;
            rdy   <= (next_state == RESP);

            if (take_req) begin
                req_addr <= cur_addr;
                if (hit) begin
                    dout <= line_byte;
                end else begin
                    DDRAM_ADDR <= BASE_WORD
                                + {{(29 - TAG_BITS){1'b0}}, cur_addr[ADDR_BITS-1:3]};
                end
            end
            if (fill) begin
                dout <= pick_byte(DDRAM_DOUT, req_addr[2:0]);
            end

            // In IDLE a held request is consumed this cycle, so a simultaneous
            // strobe takes its place; outside IDLE a strobe simply overwrites.
            if (state != IDLE) begin
                if (rd) begin
                    pend_valid <= 1'b1;
                    pend_addr  <= addr;
                end
            end else if (pend_valid) begin
                pend_valid <= rd;
                if (rd) begin
                    pend_addr <= addr;
                end
            end
        end
    end

    assign DDRAM_RD       = (state == ISSUE);
    assign DDRAM_BURSTCNT = BURST_ONE;
    assign DDRAM_WE       = 1'b0;
    assign DDRAM_DIN      = '0;
    assign DDRAM_BE       = 8'hFF;

endmodule

// File: tb/tb_pcm_rom_reader.sv
// tb_pcm_rom_reader
// Self-checking bench for pcm_rom_reader. A behavioural DDRAM (sparse word
// array filled with random data, programmable read latency) answers the
// DUT; expected bytes, latencies and command counts come from a small
// request-level model of the one-line cache (active when the bench is built
// with PCM_ROM_LINE_CACHE_EN).
`timescale 1ns/1ps
module tb_pcm_rom_reader;

    localparam logic [28:0] BASE = 29'h0600000;
`ifdef PCM_ROM_LINE_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b1;
    logic        flush   = 1'b0;
    logic        rd      = 1'b0;
    logic [17:0] addr    = '0;
    logic [7:0]  dout;
    logic        rdy;
    logic        DDRAM_BUSY = 1'b0;
    logic        DDRAM_RD;
    logic [28:0] DDRAM_ADDR;
    logic [7:0]  DDRAM_BURSTCNT;
    logic [63:0] DDRAM_DOUT = '0;
    logic        DDRAM_DOUT_READY = 1'b0;
    logic        DDRAM_WE;
    logic [63:0] DDRAM_DIN;
    logic [7:0]  DDRAM_BE;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_sys = ~clk_sys;

    pcm_rom_reader #(.BASE_WORD(BASE)) dut (
        .clk_sys          (clk_sys),
        .reset_n          (reset_n),
        .flush            (flush),
        .rd               (rd),
        .addr             (addr),
        .dout             (dout),
        .rdy              (rdy),
        .DDRAM_BUSY       (DDRAM_BUSY),
        .DDRAM_RD         (DDRAM_RD),
        .DDRAM_ADDR       (DDRAM_ADDR),
        .DDRAM_BURSTCNT   (DDRAM_BURSTCNT),
        .DDRAM_DOUT       (DDRAM_DOUT),
        .DDRAM_DOUT_READY (DDRAM_DOUT_READY),
        .DDRAM_WE         (DDRAM_WE),
        .DDRAM_DIN        (DDRAM_DIN),
        .DDRAM_BE         (DDRAM_BE)
    );

    // ---------------- behavioural DDRAM ----------------
    logic [63:0] rom [logic [28:0]];

    function automatic logic [63:0] rom_word(input logic [28:0] w);
        if (!rom.exists(w)) rom[w] = {$urandom, $urandom};
        return rom[w];
    endfunction

    int          resp_lat = 2;
    int          resp_cnt = 0;
    logic [63:0] resp_data = '0;
    logic [28:0] cmd_q[$];

    // Works on the falling edge: a command seen here is accepted by the DUT
    // on the next rising edge; READY is then driven for one cycle resp_lat
    // cycles later. Garbage is driven on DDRAM_DOUT otherwise.
    always @(negedge clk_sys) begin
        DDRAM_DOUT_READY = 1'b0;
        DDRAM_DOUT       = {$urandom, $urandom};
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                DDRAM_DOUT_READY = 1'b1;
                DDRAM_DOUT       = resp_data;
            end
        end
        if (reset_n && DDRAM_RD && !DDRAM_BUSY) begin
            cmd_q.push_back(DDRAM_ADDR);
            resp_data = rom_word(DDRAM_ADDR);
            resp_cnt  = resp_lat;
        end
    end

    int         rdy_pulses = 0;
    logic [7:0] rdy_q[$];
    always @(negedge clk_sys) begin
        if (rdy) begin
            rdy_pulses++;
            rdy_q.push_back(dout);
        end
    end

    // ---------------- reference model ----------------
    bit          m_valid = 1'b0;
    logic [14:0] m_tag   = '0;

    function automatic logic [28:0] model_word(input logic [17:0] a);
        return BASE + {14'd0, a[17:3]};
    endfunction

    function automatic logic [7:0] model_byte(input logic [17:0] a);
        logic [63:0] w;
        w = rom_word(model_word(a));
        return w[int'(a[2:0]) * 8 +: 8];
    endfunction

    function automatic bit model_hit(input logic [17:0] a);
        return CACHE_EN && m_valid && !flush && (m_tag == a[17:3]);
    endfunction

    function automatic void model_fill(input logic [17:0] a);
        m_tag   = a[17:3];
        m_valid = !flush;
    endfunction

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Drives one strobe and observes the transaction: cycles from the strobe
    // edge to rdy (-1 on timeout), byte returned, commands issued, cycles
    // with DDRAM_RD high, first command address and whether it moved.
    task automatic run_req(input logic [17:0] a, input int busy, input int lat,
                           output int cycles, output logic [7:0] got,
                           output int new_cmds, output int rd_high,
                           output logic [28:0] seen_addr, output bit addr_moved);
        int c0;
        c0         = cmd_q.size();
        resp_lat   = lat;
        cycles     = -1;
        got        = 8'hxx;
        rd_high    = 0;
        seen_addr  = 'x;
        addr_moved = 1'b0;
        DDRAM_BUSY = (busy > 0);
        rd = 1'b1; addr = a;
        tick();
        rd = 1'b0; addr = 18'($urandom);
        for (int k = 0; k <= 40 && cycles < 0; k++) begin
            if (rdy) begin
                cycles = k;
                got    = dout;
            end
            if (DDRAM_RD) begin
                if (rd_high == 0) seen_addr = DDRAM_ADDR;
                else if (DDRAM_ADDR !== seen_addr) addr_moved = 1'b1;
                rd_high++;
            end
            if (k == busy) DDRAM_BUSY = 1'b0;
            if (cycles < 0) tick();
        end
        DDRAM_BUSY = 1'b0;
        tick();
        new_cmds = cmd_q.size() - c0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (rdy !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_rdy: got %b expected 0", rdy); end
        n_cmp++; if (DDRAM_RD !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_ddram_rd: got %b expected 0", DDRAM_RD); end
        n_cmp++; if (dout !== 8'h00) begin n_bad++; $display("[TB] FAIL reset_dout: got %h expected 00", dout); end
        n_cmp++; if (DDRAM_ADDR !== BASE) begin n_bad++; $display("[TB] FAIL reset_ddram_addr: got %h expected %h", DDRAM_ADDR, BASE); end
        n_cmp++; if (DDRAM_BURSTCNT !== 8'd1) begin n_bad++; $display("[TB] FAIL reset_burstcnt: got %h expected 01", DDRAM_BURSTCNT); end
        n_cmp++; if (DDRAM_WE !== 1'b0) begin n_bad++; $display("[TB] FAIL const_we: got %b expected 0", DDRAM_WE); end
        n_cmp++; if (DDRAM_DIN !== 64'h0) begin n_bad++; $display("[TB] FAIL const_din: got %h expected 0", DDRAM_DIN); end
        n_cmp++; if (DDRAM_BE !== 8'hFF) begin n_bad++; $display("[TB] FAIL const_be: got %h expected ff", DDRAM_BE); end
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (2) tick();
        n_cmp++; if (rdy !== 1'b0 || DDRAM_RD !== 1'b0) begin n_bad++; $display("[TB] FAIL post_reset_idle: got rdy=%b rd=%b expected 0/0", rdy, DDRAM_RD); end
        m_valid = 1'b0;
    endtask

    task automatic test_cold_read();
        int cyc, nc, rh, p0; logic [7:0] got; logic [28:0] sa; bit mv;
        rom[BASE] = 64'h8877665544332211;
        p0 = rdy_pulses;
        run_req(18'h00005, 0, 4, cyc, got, nc, rh, sa, mv);
        n_cmp++; if (sa !== BASE) begin n_bad++; $display("[TB] FAIL cold_addr: got %h expected %h", sa, BASE); end
        n_cmp++; if (got !== 8'h66) begin n_bad++; $display("[TB] FAIL cold_dout: got %h expected 66", got); end
        n_cmp++; if (cyc != 5) begin n_bad++; $display("[TB] FAIL cold_latency: got %0d expected 5", cyc); end
        n_cmp++; if (rdy_pulses - p0 != 1) begin n_bad++; $display("[TB] FAIL cold_pulses: got %0d expected 1", rdy_pulses - p0); end
        n_cmp++; if (nc != 1 || rh != 1) begin n_bad++; $display("[TB] FAIL cold_cmds: got cmds=%0d rd_cycles=%0d expected 1/1", nc, rh); end
        n_cmp++; if (dout !== 8'h66) begin n_bad++; $display("[TB] FAIL cold_dout_held: got %h expected 66", dout); end
        model_fill(18'h00005);
    endtask

    task automatic test_hit();
        int cyc, nc, rh; logic [7:0] got; logic [28:0] sa; bit mv, eh;
        eh = model_hit(18'h00002);
        run_req(18'h00002, 0, 3, cyc, got, nc, rh, sa, mv);
        n_cmp++; if (got !== 8'h33) begin n_bad++; $display("[TB] FAIL hit_dout: got %h expected 33", got); end
        n_cmp++; if (cyc != (eh ? 0 : 4)) begin n_bad++; $display("[TB] FAIL hit_latency: got %0d expected %0d", cyc, eh ? 0 : 4); end
        n_cmp++; if (rh != (eh ? 0 : 1) || nc != (eh ? 0 : 1)) begin n_bad++; $display("[TB] FAIL hit_ddram_rd: got rd_cycles=%0d cmds=%0d expected %0d", rh, nc, eh ? 0 : 1); end
        if (!eh) model_fill(18'h00002);
    endtask

    task automatic test_backpressure();
        int cyc, nc, rh, lat; logic [7:0] got, eb; logic [28:0] sa; bit mv; logic [17:0] a;
        a   = {15'(16 + $urandom_range(0, 15)), 3'($urandom)};
        lat = $urandom_range(1, 4);
        eb  = model_byte(a);
        run_req(a, 5, lat, cyc, got, nc, rh, sa, mv);
        n_cmp++; if (rh != 6 || mv) begin n_bad++; $display("[TB] FAIL bp_hold: got rd_cycles=%0d moved=%0b expected 6/0", rh, mv); end
        n_cmp++; if (sa !== model_word(a)) begin n_bad++; $display("[TB] FAIL bp_addr: got %h expected %h", sa, model_word(a)); end
        n_cmp++; if (nc != 1) begin n_bad++; $display("[TB] FAIL bp_cmds: got %0d expected 1", nc); end
        n_cmp++; if (cyc != 5 + lat + 1 || got !== eb) begin n_bad++; $display("[TB] FAIL bp_resp: got cyc=%0d byte=%h expected %0d/%h", cyc, got, 6 + lat, eb); end
        model_fill(a);
    endtask

    task automatic test_pending();
        int p0, q0, c0; logic [17:0] a1, a2;
        a1 = {15'd2, 3'($urandom)};
        a2 = {15'd3, 3'($urandom)};
        p0 = rdy_pulses; q0 = rdy_q.size(); c0 = cmd_q.size();
        resp_lat = 3;
        rd = 1'b1; addr = a1; tick(); rd = 1'b0;
        tick();
        rd = 1'b1; addr = a2; tick(); rd = 1'b0;
        for (int i = 0; i < 40 && rdy_pulses - p0 < 2; i++) tick();
        repeat (3) tick();
        n_cmp++; if (cmd_q.size() != c0 + 2 || cmd_q[c0] !== model_word(a1) || cmd_q[c0+1] !== model_word(a2)) begin
            n_bad++; $display("[TB] FAIL pend_cmds: got %0d cmds expected 2 to %h then %h", cmd_q.size() - c0, model_word(a1), model_word(a2)); end
        n_cmp++; if (rdy_pulses - p0 != 2) begin n_bad++; $display("[TB] FAIL pend_pulses: got %0d expected 2", rdy_pulses - p0); end
        n_cmp++; if (rdy_q.size() < q0 + 2 || rdy_q[q0] !== model_byte(a1) || rdy_q[q0+1] !== model_byte(a2)) begin
            n_bad++; $display("[TB] FAIL pend_bytes: got %0d bytes expected %h,%h", rdy_q.size() - q0, model_byte(a1), model_byte(a2)); end
        model_fill(a2);
    endtask

    task automatic test_last_wins();
        int p0, q0, c0; logic [17:0] a, b, c;
        a = {15'd40, 3'($urandom)};
        b = {15'd41, 3'($urandom)};
        c = {15'd42, 3'($urandom)};
        p0 = rdy_pulses; q0 = rdy_q.size(); c0 = cmd_q.size();
        resp_lat = 6;
        rd = 1'b1; addr = a; tick(); rd = 1'b0;
        tick();
        rd = 1'b1; addr = b; tick();
        addr = c; tick(); rd = 1'b0;
        for (int i = 0; i < 50 && rdy_pulses - p0 < 2; i++) tick();
        repeat (4) tick();
        n_cmp++; if (cmd_q.size() != c0 + 2 || cmd_q[c0+1] !== model_word(c)) begin
            n_bad++; $display("[TB] FAIL last_wins_cmds: got %0d cmds expected 2 ending at %h", cmd_q.size() - c0, model_word(c)); end
        n_cmp++; if (rdy_pulses - p0 != 2 || rdy_q.size() < q0 + 2 || rdy_q[q0+1] !== model_byte(c)) begin
            n_bad++; $display("[TB] FAIL last_wins_resp: got %0d pulses expected 2 ending with %h", rdy_pulses - p0, model_byte(c)); end
        model_fill(c);
    endtask

    task automatic test_back_to_back();
        int p0, q0, c0; bit hb; logic [17:0] a, b;
        a = {15'd44, 3'($urandom)};
        b = {15'd44, 3'($urandom)};
        p0 = rdy_pulses; q0 = rdy_q.size(); c0 = cmd_q.size();
        resp_lat = 2;
        rd = 1'b1; addr = a; tick(); rd = 1'b0;
        for (int i = 0; i < 30 && !rdy; i++) tick();
        model_fill(a);
        hb = model_hit(b);
        rd = 1'b1; addr = b; tick(); rd = 1'b0;
        for (int i = 0; i < 40 && rdy_pulses - p0 < 2; i++) tick();
        repeat (2) tick();
        n_cmp++; if (rdy_pulses - p0 != 2) begin n_bad++; $display("[TB] FAIL b2b_pulses: got %0d expected 2", rdy_pulses - p0); end
        n_cmp++; if (rdy_q.size() < q0 + 2 || rdy_q[q0] !== model_byte(a) || rdy_q[q0+1] !== model_byte(b)) begin
            n_bad++; $display("[TB] FAIL b2b_bytes: got %0d bytes expected %h,%h", rdy_q.size() - q0, model_byte(a), model_byte(b)); end
        n_cmp++; if (cmd_q.size() - c0 != (hb ? 1 : 2)) begin n_bad++; $display("[TB] FAIL b2b_cmds: got %0d expected %0d", cmd_q.size() - c0, hb ? 1 : 2); end
        if (!hb) model_fill(b);
    endtask

    task automatic test_flush();
        int cyc, nc, rh, p0; logic [7:0] got, eb; logic [28:0] sa; bit mv; logic [17:0] a;
        a  = {15'd50, 3'($urandom)};
        eb = model_byte(a);
        p0 = rdy_pulses;
        resp_lat = 4;
        got = 8'hxx;
        rd = 1'b1; addr = a; tick(); rd = 1'b0;
        tick(); tick();
        flush = 1'b1;
        cyc = -1;
        for (int i = 0; i < 30 && cyc < 0; i++) begin
            if (rdy) begin cyc = i; got = dout; end
            else tick();
        end
        model_fill(a);
        tick();
        flush = 1'b0;
        n_cmp++; if (got !== eb || rdy_pulses - p0 != 1) begin n_bad++; $display("[TB] FAIL flush_first_resp: got byte=%h pulses=%0d expected %h/1", got, rdy_pulses - p0, eb); end
        a  = {15'd50, 3'($urandom)};
        eb = model_byte(a);
        run_req(a, 0, 2, cyc, got, nc, rh, sa, mv);
        n_cmp++; if (nc != 1 || got !== eb) begin n_bad++; $display("[TB] FAIL flush_refetch: got cmds=%0d byte=%h expected 1/%h", nc, got, eb); end
        model_fill(a);
        flush = 1'b1;
        a  = {15'd50, 3'($urandom)};
        eb = model_byte(a);
        run_req(a, 0, 2, cyc, got, nc, rh, sa, mv);
        model_fill(a);
        flush = 1'b0;
        n_cmp++; if (nc != 1 || cyc != 3 || got !== eb) begin n_bad++; $display("[TB] FAIL rd_during_flush: got cmds=%0d cyc=%0d byte=%h expected 1/3/%h", nc, cyc, got, eb); end
        run_req(a, 0, 1, cyc, got, nc, rh, sa, mv);
        n_cmp++; if (nc != 1 || got !== eb) begin n_bad++; $display("[TB] FAIL fill_under_flush_invalid: got cmds=%0d byte=%h expected 1/%h", nc, got, eb); end
        model_fill(a);
    endtask

    task automatic test_wrap();
        int cyc, nc, rh, lat; logic [7:0] got; logic [28:0] sa; bit mv, eh; logic [63:0] w;
        w   = rom_word(BASE + 29'h7FFF);
        lat = $urandom_range(1, 5);
        eh  = model_hit(18'h3FFFF);
        run_req(18'h3FFFF, 0, lat, cyc, got, nc, rh, sa, mv);
        n_cmp++; if (sa !== BASE + 29'h7FFF) begin n_bad++; $display("[TB] FAIL wrap_addr: got %h expected %h", sa, BASE + 29'h7FFF); end
        n_cmp++; if (got !== w[63:56]) begin n_bad++; $display("[TB] FAIL wrap_dout: got %h expected %h", got, w[63:56]); end
        n_cmp++; if (cyc != (eh ? 0 : lat + 1)) begin n_bad++; $display("[TB] FAIL wrap_latency: got %0d expected %0d", cyc, eh ? 0 : lat + 1); end
        model_fill(18'h3FFFF);
    endtask

    task automatic test_reset_mid();
        int p0, rd_seen, cyc, nc, rh; logic [7:0] got, eb; logic [28:0] sa; bit mv; logic [17:0] a;
        a = {15'd60, 3'($urandom)};
        p0 = rdy_pulses;
        resp_lat = 6;
        rd = 1'b1; addr = a; tick(); rd = 1'b0;
        tick(); tick();
        n_cmp++; if (DDRAM_ADDR !== model_word(a)) begin n_bad++; $display("[TB] FAIL mid_addr_before_reset: got %h expected %h", DDRAM_ADDR, model_word(a)); end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (DDRAM_ADDR !== BASE || dout !== 8'h00 || rdy !== 1'b0) begin
            n_bad++; $display("[TB] FAIL mid_async_reset: got addr=%h dout=%h rdy=%b expected %h/00/0", DDRAM_ADDR, dout, rdy, BASE); end
        tick();
        reset_n = 1'b1;
        m_valid = 1'b0;
        rd_seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (DDRAM_RD) rd_seen++;
            tick();
        end
        n_cmp++; if (rdy_pulses != p0 || rd_seen != 0) begin n_bad++; $display("[TB] FAIL stale_ready_ignored: got pulses=%0d rd_cycles=%0d expected 0/0", rdy_pulses - p0, rd_seen); end
        eb = model_byte(a);
        run_req(a, 0, 2, cyc, got, nc, rh, sa, mv);
        n_cmp++; if (nc != 1 || cyc != 3 || got !== eb) begin n_bad++; $display("[TB] FAIL mid_recovery: got cmds=%0d cyc=%0d byte=%h expected 1/3/%h", nc, cyc, got, eb); end
        model_fill(a);
    endtask

    task automatic test_random();
        int cyc, nc, rh, busy, lat; logic [7:0] got, eb; logic [28:0] sa; bit mv, eh; logic [17:0] a;
        for (int n = 0; n < 24; n++) begin
            a    = {15'(70 + $urandom_range(0, 3)), 3'($urandom)};
            busy = $urandom_range(0, 2);
            lat  = $urandom_range(1, 5);
            eh   = model_hit(a);
            eb   = model_byte(a);
            run_req(a, busy, lat, cyc, got, nc, rh, sa, mv);
            n_cmp++; if (got !== eb) begin n_bad++; $display("[TB] FAIL rand_dout[%0d]: got %h expected %h", n, got, eb); end
            n_cmp++; if (cyc != (eh ? 0 : busy + lat + 1)) begin n_bad++; $display("[TB] FAIL rand_latency[%0d]: got %0d expected %0d", n, cyc, eh ? 0 : busy + lat + 1); end
            n_cmp++; if (nc != (eh ? 0 : 1) || (!eh && sa !== model_word(a))) begin
                n_bad++; $display("[TB] FAIL rand_cmd[%0d]: got cmds=%0d addr=%h expected %0d/%h", n, nc, sa, eh ? 0 : 1, model_word(a)); end
            if (!eh) model_fill(a);
        end
    endtask

    initial begin
        $display("[TB] pcm_rom_reader bench, line cache %s", CACHE_EN ? "enabled" : "disabled");
        test_reset();
        test_cold_read();
        test_hit();
        test_backpressure();
        test_pending();
        test_last_wins();
        test_back_to_back();
        test_flush();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete, %0d compared so far", n_cmp);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
